// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory handshakes.
// Optional feature: define ILLEGAL_TRAP_EN to park illegal opcodes in TRAP until trap_ack.
module multicycle_control_unit #(
  parameter int ALU_OP_W       = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [6:0]          opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                stall,
  input  logic                trap_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                pc_write,
  output logic                ir_write,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_2_reg,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic                mem_timeout,
  output logic                illegal_instr,
  output logic                retired,
  output logic [CNT_W-1:0]    retired_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_load, is_store, timeout_hit;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL) ||
           (op == OP_LOAD) || (op == OP_STORE);
  endfunction

`ifndef ILLEGAL_TRAP_EN
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
`endif

  assign is_load     = (opcode_q == OP_LOAD);
  assign is_store    = (opcode_q == OP_STORE);
  assign timeout_hit = (state_q == S_MEM) && !stall && !dmem_ready && (timer_q == TMR_LAST);

  assign state       = state_q;
  assign retired_cnt = cnt_q;

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    timer_d       = timer_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    alu_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_2_reg     = 1'b0;
    reg_write     = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_op        = '0;
    mem_timeout   = 1'b0;
    illegal_instr = 1'b0;
    retired       = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !stall) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!stall) begin
          opcode_d = opcode;
          if (is_legal(opcode)) begin
            state_d = S_EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end

      S_EXEC: begin
        case (opcode_q)
          OP_R: begin
            alu_op = ALU_OP_W'(2'b10);
            if (!stall) state_d = S_WB;
          end
          OP_I: begin
            alu_src = 1'b1;
            if (!stall) state_d = S_WB;
          end
          OP_BEQ: begin
            alu_op = ALU_OP_W'(2'b01);
            branch = 1'b1;
            if (!stall) begin
              retired = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_JAL: begin
            jump = 1'b1;
            if (!stall) begin
              retired = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_LOAD, OP_STORE: begin
            alu_src = 1'b1;
            if (!stall) begin
              timer_d = '0;
              state_d = S_MEM;
            end
          end
          default: begin
            if (!stall) state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        dmem_req  = 1'b1;
        alu_src   = 1'b1;
        mem_read  = is_load;
        // An aborted store must not look like a write on its final cycle.
        mem_write = is_store && !stall && !timeout_hit;
        if (!stall) begin
          if (dmem_ready) begin
            timer_d = '0;
            if (is_load) begin
              state_d = S_WB;
            end else begin
              retired = 1'b1;
              state_d = S_FETCH;
            end
          end else if (timeout_hit) begin
            mem_timeout = 1'b1;
            timer_d     = '0;
            state_d     = S_FETCH;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end

      S_WB: begin
        mem_2_reg = is_load;
        if (!stall) begin
          reg_write = 1'b1;
          retired   = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b1;
        if (!stall && trap_ack) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase

    // While reset is asserted every output except state reads as zero.
    if (!arst_n) begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      alu_src       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_2_reg     = 1'b0;
      reg_write     = 1'b0;
      branch        = 1'b0;
      jump          = 1'b0;
      alu_op        = '0;
      mem_timeout   = 1'b0;
      illegal_instr = 1'b0;
      retired       = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retired) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - bench for multicycle_control_unit: vector table, directed corners, random vs route model.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, stall = 1'b0, trap_ack = 1'b0;
  logic        imem_req, dmem_req, pc_write, ir_write, alu_src, mem_read, mem_write;
  logic        mem_2_reg, reg_write, branch, jump, mem_timeout, illegal_instr, retired;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired_cnt;

  multicycle_control_unit #(.ALU_OP_W(2), .TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .stall(stall), .trap_ack(trap_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .pc_write(pc_write), .ir_write(ir_write),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write), .mem_2_reg(mem_2_reg),
    .reg_write(reg_write), .branch(branch), .jump(jump), .alu_op(alu_op), .state(state),
    .mem_timeout(mem_timeout), .illegal_instr(illegal_instr), .retired(retired),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // 0 illegal, 1 R, 2 I, 3 BEQ, 4 JAL, 5 LOAD, 6 STORE
  function automatic int kind(input logic [6:0] op);
    case (op)
      OP_R:     return 1;
      OP_I:     return 2;
      OP_BEQ:   return 3;
      OP_JAL:   return 4;
      OP_LOAD:  return 5;
      OP_STORE: return 6;
      default:  return 0;
    endcase
  endfunction

  // Reference model: each instruction is a list of phases still to visit after DECODE.
  int          m_ph;
  logic [6:0]  m_op;
  int          m_route[$];
  int          m_memcyc;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_ph = 0; m_op = '0; m_route.delete(); m_memcyc = 0; m_cnt = '0;
  endtask

  task automatic advance();
    if (m_route.size() == 0) begin
      m_ph = 0;
      m_cnt++;
    end else begin
      m_ph = m_route.pop_front();
      if (m_ph == 3) m_memcyc = 0;
    end
  endtask

  task automatic model_cycle(output logic [18:0] ev);
    logic ir, dr, pw, iw, as, mr, mw, m2r, rw, br, jp, mt, ii, rt, done, to;
    logic [1:0] aop;
    logic [2:0] st;
    int k;
    {ir, dr, pw, iw, as, mr, mw, m2r, rw, br, jp, mt, ii, rt, done, to} = '0;
    aop = 2'd0;
    st  = 3'(m_ph);
    k   = kind(m_op);
    case (m_ph)
      0: begin
        ir = 1'b1;
        if (imem_ready && !stall) begin pw = 1'b1; iw = 1'b1; m_ph = 1; end
      end
      1: if (!stall) begin
        m_op = opcode;
        case (kind(opcode))
          1, 2:    m_route = '{2, 4};
          3, 4:    m_route = '{2};
          5:       m_route = '{2, 3, 4};
          6:       m_route = '{2, 3};
`ifdef ILLEGAL_TRAP_EN
          default: m_route = '{5};
`else
          default: m_route.delete();
`endif
        endcase
        if (m_route.size() == 0) m_ph = 0;
        else m_ph = m_route.pop_front();
      end
      2: begin
        aop = (k == 1) ? 2'd2 : (k == 3) ? 2'd1 : 2'd0;
        as  = (k == 2) || (k == 5) || (k == 6);
        br  = (k == 3);
        jp  = (k == 4);
        if (!stall) begin rt = (m_route.size() == 0); advance(); end
      end
      3: begin
        dr   = 1'b1;
        as   = 1'b1;
        mr   = (k == 5);
        done = dmem_ready && !stall;
        to   = !stall && !dmem_ready && (m_memcyc + 1 == 16);
        mw   = (k == 6) && !stall && !to;
        mt   = to;
        if (done) begin rt = (m_route.size() == 0); advance(); end
        else if (to) begin m_route.delete(); m_ph = 0; end
        else if (!stall) m_memcyc++;
      end
      4: begin
        m2r = (k == 5);
        if (!stall) begin rw = 1'b1; rt = (m_route.size() == 0); advance(); end
      end
      default: begin
        ii = 1'b1;
        if (!stall && trap_ack) m_ph = 0;
      end
    endcase
    ev = {ir, dr, pw, iw, as, mr, mw, m2r, rw, br, jp, mt, ii, rt, aop, st};
  endtask

  function automatic logic [18:0] act_vec();
    return {imem_req, dmem_req, pc_write, ir_write, alu_src, mem_read, mem_write, mem_2_reg,
            reg_write, branch, jump, mem_timeout, illegal_instr, retired, alu_op, state};
  endfunction

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step(input string tag);
    logic [18:0] ev;
    logic [31:0] ecnt;
    @(negedge clk);
    ecnt = m_cnt;
    model_cycle(ev);
    check({tag, " outputs"}, 64'(act_vec()), 64'(ev));
    check({tag, " retired_cnt"}, 64'(retired_cnt), 64'(ecnt));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int dwait, output int cycles);
    int memseen;
    memseen = 0;
    cycles  = 0;
    opcode  = op;
    stall   = 1'b0;
    trap_ack = 1'b1;
    while (cycles < 40) begin
      imem_ready = (cycles == 0);
      dmem_ready = (m_ph == 3) && (dwait >= 0) && (memseen >= dwait);
      if (m_ph == 3) memseen++;
      step("vec");
      cycles++;
      if (state == 3'd0) break;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    trap_ack   = 1'b0;
  endtask

  typedef struct {
    logic [6:0] op;
    int         dwait;
    int         exp_cycles;
    int         exp_ret;
  } vec_t;

  vec_t vecs[10];
  logic [6:0] legal_ops[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [31:0] c0;

    vecs[0] = '{OP_R,     0,  4, 1};
    vecs[1] = '{OP_I,     0,  4, 1};
    vecs[2] = '{OP_BEQ,   0,  3, 1};
    vecs[3] = '{OP_JAL,   0,  3, 1};
    vecs[4] = '{OP_LOAD,  0,  5, 1};
    vecs[5] = '{OP_LOAD,  3,  8, 1};
    vecs[6] = '{OP_STORE, 0,  4, 1};
    vecs[7] = '{OP_STORE, 2,  6, 1};
    vecs[8] = '{OP_STORE, -1, 19, 0};
`ifdef ILLEGAL_TRAP_EN
    vecs[9] = '{OP_BAD,   0,  3, 0};
`else
    vecs[9] = '{OP_BAD,   0,  2, 0};
`endif
    legal_ops = '{OP_R, OP_I, OP_BEQ, OP_JAL, OP_LOAD, OP_STORE};

    // Reset with a ready input pending: everything but state must stay low.
    model_reset();
    imem_ready = 1'b1;
    #2;
    check("reset outputs", 64'(act_vec()), 64'd0);
    check("reset retired_cnt", 64'(retired_cnt), 64'd0);
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    arst_n = 1'b1;

    foreach (vecs[i]) begin
      c0 = retired_cnt;
      run_instr(vecs[i].op, vecs[i].dwait, cyc);
      check($sformatf("vec%0d latency", i), 64'(cyc), 64'(vecs[i].exp_cycles));
      check($sformatf("vec%0d retire delta", i), 64'(retired_cnt - c0), 64'(vecs[i].exp_ret));
    end

    // Stall held for five cycles in WB of an I-type.
    c0 = retired_cnt;
    opcode = OP_I;
    imem_ready = 1'b1; step("stall");
    imem_ready = 1'b0; step("stall");
    step("stall");
    check("stall in WB", 64'(state), 64'd4);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall reg_write", 64'(reg_write), 64'd0);
      step("stall");
    end
    stall = 1'b0;
    #1;
    check("unstall reg_write", 64'(reg_write), 64'd1);
    step("stall");
    check("stall count", 64'(retired_cnt), 64'(c0 + 1));

    // Illegal opcode 1111111.
    c0 = retired_cnt;
    opcode = OP_BAD;
    imem_ready = 1'b1; step("illegal");
    imem_ready = 1'b0; step("illegal");
`ifdef ILLEGAL_TRAP_EN
    trap_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("trap illegal_instr", 64'(illegal_instr), 64'd1);
      step("trap");
    end
    trap_ack = 1'b1;
    step("trap");
    trap_ack = 1'b0;
`endif
    check("illegal back to fetch", 64'(state), 64'd0);
    check("illegal count", 64'(retired_cnt), 64'(c0));

    // Asynchronous reset in the middle of a LOAD's MEM wait.
    opcode = OP_LOAD;
    imem_ready = 1'b1; step("rstmem");
    imem_ready = 1'b0; step("rstmem");
    step("rstmem");
    step("rstmem");
    check("rstmem in MEM", 64'(state), 64'd3);
    #1;
    arst_n = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check("rstmem outputs", 64'(act_vec()), 64'd0);
    check("rstmem retired_cnt", 64'(retired_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    arst_n = 1'b1;

    // Random traffic against the route model.
    for (int i = 0; i < 600; i++) begin
      stall      = ($urandom_range(0, 4) == 0);
      imem_ready = $urandom_range(0, 1) == 1;
      dmem_ready = ($urandom_range(0, 2) == 0);
      trap_ack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 8) opcode = legal_ops[$urandom_range(0, 5)];
      else opcode = 7'($urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
